// File: rtl/fft_pkg.sv
// Shared defaults, magnitude width helper and state encoding for the FFT peak detector.
package fft_pkg;

    localparam int DEF_IWIDTH = 8;
    localparam int DEF_LGSIZE = 7;
    localparam int DEF_MAG_W  = 2 * DEF_IWIDTH;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } peak_state_t;

    // re^2 + im^2 of two IWIDTH-bit signed values always fits in 2*IWIDTH unsigned bits
    function automatic int mag_width(input int iwidth);
        return 2 * iwidth;
    endfunction

endpackage

// File: rtl/fft_cmag.sv
// Squared magnitude of one complex FFT bin with one registered cycle of latency;
// the bin index travels alongside so the result stays tagged regardless of later strobes.
module fft_cmag
    import fft_pkg::*;
#(
    parameter int IWIDTH = DEF_IWIDTH,
    parameter int LGSIZE = DEF_LGSIZE
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_ce,
    input  logic [2*IWIDTH-1:0] i_result,
    input  logic [LGSIZE-1:0]   i_bin,
    output logic                o_valid,
    output logic [2*IWIDTH-1:0] o_mag,
    output logic [LGSIZE-1:0]   o_bin
);

    localparam int MW = mag_width(IWIDTH);

    logic signed [MW-1:0] re_ext;
    logic signed [MW-1:0] im_ext;
    logic signed [MW-1:0] re_sq;
    logic signed [MW-1:0] im_sq;
    logic [MW-1:0]        mag_sum;

    // Squares are non-negative and at most 2^(2*IWIDTH-2), so the unsigned sum cannot wrap
    assign re_ext  = {{(MW-IWIDTH){i_result[2*IWIDTH-1]}}, i_result[2*IWIDTH-1:IWIDTH]};
    assign im_ext  = {{(MW-IWIDTH){i_result[IWIDTH-1]}}, i_result[IWIDTH-1:0]};
    assign re_sq   = re_ext * re_ext;
    assign im_sq   = im_ext * im_ext;
    assign mag_sum = $unsigned(re_sq) + $unsigned(im_sq);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_valid <= 1'b0;
            o_mag   <= '0;
            o_bin   <= '0;
        end else begin
            o_valid <= i_ce;
            if (i_ce) begin
                o_mag <= mag_sum;
                o_bin <= i_bin;
            end
        end
    end

endmodule

// File: rtl/fft_peak_detect.sv
// Streaming FFT peak detector: reports the strongest bin of every frame over a valid/ready port.
// Define FFT_PEAK_HALFBAND_EN to search only the positive-frequency bins 1..2^(LGSIZE-1)-1.
module fft_peak_detect
    import fft_pkg::*;
#(
    parameter int IWIDTH = DEF_IWIDTH,
    parameter int LGSIZE = DEF_LGSIZE
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_ce,
    input  logic                i_sync,
    input  logic [2*IWIDTH-1:0] i_result,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [LGSIZE-1:0]   o_bin,
    output logic [2*IWIDTH-1:0] o_mag,
    output logic                o_overrun
);

    localparam int MW = mag_width(IWIDTH);

    peak_state_t       state;
    logic [LGSIZE-1:0] bin_cnt;
    logic [LGSIZE-1:0] in_bin;
    logic              in_accept;

    logic              s1_valid;
    logic [MW-1:0]     s1_mag;
    logic [LGSIZE-1:0] s1_bin;
    logic              s1_search;
    logic              s1_first;
    logic              s1_last;

    logic [MW-1:0]     best_mag;
    logic [LGSIZE-1:0] best_bin;
    logic [MW-1:0]     cand_mag;
    logic [LGSIZE-1:0] cand_bin;
    logic              take;
    logic              load;

    // A sync restarts the frame at bin 0 wherever the counter happens to be
    assign in_accept = i_ce && (i_sync || (state == ST_ACCUM));
    assign in_bin    = i_sync ? '0 : bin_cnt;

    fft_cmag #(
        .IWIDTH(IWIDTH),
        .LGSIZE(LGSIZE)
    ) u_cmag (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_ce    (in_accept),
        .i_result(i_result),
        .i_bin   (in_bin),
        .o_valid (s1_valid),
        .o_mag   (s1_mag),
        .o_bin   (s1_bin)
    );

`ifdef FFT_PEAK_HALFBAND_EN
    assign s1_search = (s1_bin != '0) && !s1_bin[LGSIZE-1];
    assign s1_first  = (s1_bin == LGSIZE'(1));
`else
    assign s1_search = 1'b1;
    assign s1_first  = (s1_bin == '0);
`endif

    // Strict compare keeps the lowest bin on ties; the first searched bin reseeds the search
    assign s1_last  = &s1_bin;
    assign take     = s1_valid && s1_search && (s1_first || (s1_mag > best_mag));
    assign load     = s1_valid && s1_last;
    assign cand_mag = take ? s1_mag : best_mag;
    assign cand_bin = take ? s1_bin : best_bin;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_IDLE;
            bin_cnt   <= '0;
            best_mag  <= '0;
            best_bin  <= '0;
            o_valid   <= 1'b0;
            o_bin     <= '0;
            o_mag     <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (in_accept) begin
                state   <= ST_ACCUM;
                bin_cnt <= in_bin + LGSIZE'(1);
            end
            if (take) begin
                best_mag <= s1_mag;
                best_bin <= s1_bin;
            end
            // A load wins over a same-cycle transfer; only an unconsumed report counts as overrun
            if (load) begin
                o_valid <= 1'b1;
                o_bin   <= cand_bin;
                o_mag   <= cand_mag;
                if (o_valid && !i_ready) begin
                    o_overrun <= 1'b1;
                end
            end else if (o_valid && i_ready) begin
                o_valid   <= 1'b0;
                o_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect: a frame-level behavioural model checked every cycle,
// plus directed frames with hand-computed expectations and a randomized phase.
module tb_fft_peak_detect;

    localparam int NBINS = 128;

    logic        i_clk;
    logic        i_reset;
    logic        i_ce;
    logic        i_sync;
    logic [15:0] i_result;
    logic        o_valid;
    logic        i_ready;
    logic [6:0]  o_bin;
    logic [15:0] o_mag;
    logic        o_overrun;

    int total = 0;
    int bad   = 0;
    bit rand_ready = 0;

    logic signed [7:0] frame_re [NBINS];
    logic signed [7:0] frame_im [NBINS];

    bit model_live = 0;
    bit exp_valid;
    bit exp_ovr;
    int exp_bin;
    int exp_mag;
    bit m_active;
    int m_cnt;
    int m_mag [NBINS];
    bit pend_load;
    int pend_bin;
    int pend_mag;

    fft_peak_detect dut (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_ce     (i_ce),
        .i_sync   (i_sync),
        .i_result (i_result),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_bin    (o_bin),
        .o_mag    (o_mag),
        .o_overrun(o_overrun)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        if (rand_ready) i_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic applyStimulus(input bit sync, input logic signed [7:0] re,
                                 input logic signed [7:0] im, input int gap);
        i_ce     = 1'b1;
        i_sync   = sync;
        i_result = {re, im};
        tick();
        i_ce     = 1'b0;
        i_sync   = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
        i_result = 16'($urandom);
        repeat (gap) tick();
    endtask

    // gap < 0 picks a random idle gap of 0..3 cycles per bin
    task automatic sendFrame(input int nbins, input int gap, input bit with_sync);
        for (int b = 0; b < nbins; b++) begin
            applyStimulus(with_sync && (b == 0), frame_re[b], frame_im[b],
                          (gap < 0) ? int'($urandom_range(0, 3)) : gap);
        end
    endtask

    task automatic clearFrame();
        for (int b = 0; b < NBINS; b++) begin
            frame_re[b] = 8'sd0;
            frame_im[b] = 8'sd0;
        end
    endtask

    task automatic drain(input string name);
        i_ready = 1'b1;
        tick();
        checkOutput({name, "_drain_valid"}, 32'(o_valid), 32'd0);
        checkOutput({name, "_drain_ovr"}, 32'(o_overrun), 32'd0);
        i_ready = 1'b0;
    endtask

    function automatic void find_peak(output int pb, output int pm);
        int lo;
        int hi;
`ifdef FFT_PEAK_HALFBAND_EN
        lo = 1;
        hi = NBINS / 2 - 1;
`else
        lo = 0;
        hi = NBINS - 1;
`endif
        pb = lo;
        pm = m_mag[lo];
        for (int b = lo + 1; b <= hi; b++) begin
            if (m_mag[b] > pm) begin
                pb = b;
                pm = m_mag[b];
            end
        end
    endfunction

    // Frame model: collect magnitudes per bin, pick the peak when bin 127 arrives, present it next edge
    initial begin
        forever begin
            @(posedge i_clk);
            if (i_reset) begin
                model_live = 1;
                exp_valid  = 0;
                exp_ovr    = 0;
                exp_bin    = 0;
                exp_mag    = 0;
                m_active   = 0;
                m_cnt      = 0;
                pend_load  = 0;
            end else begin
                if (pend_load) begin
                    if (exp_valid && !i_ready) exp_ovr = 1;
                    exp_valid = 1;
                    exp_bin   = pend_bin;
                    exp_mag   = pend_mag;
                end else if (exp_valid && i_ready) begin
                    exp_valid = 0;
                    exp_ovr   = 0;
                end
                pend_load = 0;
                if (i_ce && (i_sync || m_active)) begin
                    int re;
                    int im;
                    re = int'($signed(i_result[15:8]));
                    im = int'($signed(i_result[7:0]));
                    if (i_sync) m_cnt = 0;
                    m_active     = 1;
                    m_mag[m_cnt] = re * re + im * im;
                    if (m_cnt == NBINS - 1) begin
                        pend_load = 1;
                        find_peak(pend_bin, pend_mag);
                    end
                    m_cnt = (m_cnt + 1) % NBINS;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge i_clk);
            if (model_live) begin
                checkOutput("cyc_valid", 32'(o_valid), 32'(exp_valid));
                checkOutput("cyc_overrun", 32'(o_overrun), 32'(exp_ovr));
                checkOutput("cyc_bin", 32'(o_bin), exp_bin);
                checkOutput("cyc_mag", 32'(o_mag), exp_mag);
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int len;
        i_reset  = 1'b1;
        i_ce     = 1'b0;
        i_sync   = 1'b0;
        i_ready  = 1'b0;
        i_result = 16'd0;
        repeat (3) @(negedge i_clk);
        checkOutput("rst_valid", 32'(o_valid), 32'd0);
        checkOutput("rst_bin", 32'(o_bin), 32'd0);
        checkOutput("rst_mag", 32'(o_mag), 32'd0);
        checkOutput("rst_ovr", 32'(o_overrun), 32'd0);
        i_reset = 1'b0;
        tick();

        $display("[TB] single peak at bin 5");
        clearFrame();
        frame_re[5] = 8'sd100;
        sendFrame(NBINS, 0, 1);
        checkOutput("bin5_not_early", 32'(o_valid), 32'd0);
        tick();
        checkOutput("bin5_valid_lat2", 32'(o_valid), 32'd1);
        checkOutput("bin5_bin", 32'(o_bin), 32'd5);
        checkOutput("bin5_mag", 32'(o_mag), 32'd10000);
        checkOutput("bin5_model_bin", exp_bin, 32'd5);
        checkOutput("bin5_model_mag", exp_mag, 32'd10000);
        drain("bin5");

        $display("[TB] all bins at most negative value");
        for (int b = 0; b < NBINS; b++) begin
            frame_re[b] = -8'sd128;
            frame_im[b] = -8'sd128;
        end
        sendFrame(NBINS, 0, 1);
        tick();
`ifdef FFT_PEAK_HALFBAND_EN
        checkOutput("maxneg_bin", 32'(o_bin), 32'd1);
`else
        checkOutput("maxneg_bin", 32'(o_bin), 32'd0);
`endif
        checkOutput("maxneg_mag", 32'(o_mag), 32'd32768);
        drain("maxneg");

        $display("[TB] tie between bins 10 and 20");
        clearFrame();
        frame_re[10] = 8'sd3;
        frame_im[10] = 8'sd4;
        frame_re[20] = 8'sd3;
        frame_im[20] = 8'sd4;
        sendFrame(NBINS, 0, 1);
        tick();
        checkOutput("tie_bin", 32'(o_bin), 32'd10);
        checkOutput("tie_mag", 32'(o_mag), 32'd25);
        drain("tie");

        $display("[TB] two reports without ready");
        clearFrame();
        frame_re[7] = 8'sd50;
        sendFrame(NBINS, 0, 1);
        tick();
        checkOutput("ovr_first_bin", 32'(o_bin), 32'd7);
        checkOutput("ovr_first_flag", 32'(o_overrun), 32'd0);
        clearFrame();
        frame_im[9] = -8'sd60;
        sendFrame(NBINS, 0, 1);
        tick();
        checkOutput("ovr_second_bin", 32'(o_bin), 32'd9);
        checkOutput("ovr_second_mag", 32'(o_mag), 32'd3600);
        checkOutput("ovr_second_flag", 32'(o_overrun), 32'd1);
        drain("ovr");

        $display("[TB] sync mid-frame discards partial frame");
        clearFrame();
        frame_re[30] = 8'sd127;
        frame_im[30] = 8'sd127;
        sendFrame(60, 0, 1);
        clearFrame();
        frame_re[40] = 8'sd20;
        sendFrame(NBINS, 0, 1);
        checkOutput("abort_no_report", 32'(o_valid), 32'd0);
        tick();
        checkOutput("abort_bin", 32'(o_bin), 32'd40);
        checkOutput("abort_mag", 32'(o_mag), 32'd400);
        drain("abort");

        $display("[TB] sparse strobes with reset mid-frame");
        sendFrame(64, 2, 1);
        i_reset  = 1'b1;
        i_ce     = 1'b1;
        i_result = {8'sd90, 8'sd0};
        tick();
        i_reset = 1'b0;
        i_ce    = 1'b0;
        checkOutput("midrst_valid", 32'(o_valid), 32'd0);
        checkOutput("midrst_bin", 32'(o_bin), 32'd0);
        checkOutput("midrst_mag", 32'(o_mag), 32'd0);
        checkOutput("midrst_ovr", 32'(o_overrun), 32'd0);
        sendFrame(NBINS, 2, 0);
        repeat (4) tick();
        checkOutput("idle_no_report", 32'(o_valid), 32'd0);
        clearFrame();
        frame_re[100] = -8'sd7;
        frame_im[100] = 8'sd9;
        frame_re[64]  = 8'sd5;
        frame_im[64]  = 8'sd5;
        frame_re[33]  = 8'sd2;
        frame_im[33]  = 8'sd2;
        sendFrame(NBINS, 2, 1);
        checkOutput("sparse_valid", 32'(o_valid), 32'd1);
`ifdef FFT_PEAK_HALFBAND_EN
        checkOutput("sparse_bin", 32'(o_bin), 32'd33);
        checkOutput("sparse_mag", 32'(o_mag), 32'd8);
`else
        checkOutput("sparse_bin", 32'(o_bin), 32'd100);
        checkOutput("sparse_mag", 32'(o_mag), 32'd130);
`endif
        drain("sparse");

        $display("[TB] randomized frames");
        rand_ready = 1;
        for (int f = 0; f < 24; f++) begin
            for (int b = 0; b < NBINS; b++) begin
                if ($urandom_range(0, 1) == 0) begin
                    frame_re[b] = 8'($urandom);
                    frame_im[b] = 8'($urandom);
                end else begin
                    frame_re[b] = 8'(int'($urandom_range(0, 6)) - 3);
                    frame_im[b] = 8'(int'($urandom_range(0, 6)) - 3);
                end
            end
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NBINS - 1)) : NBINS;
            sendFrame(len, -1, $urandom_range(0, 5) != 0);
        end
        rand_ready = 0;
        i_ready    = 1'b1;
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_peak_detect.md
FFT_PEAK_DETECT -- requirements
Module: fft_peak_detect

Interface
REQ-001 SHALL have parameter IWIDTH, default 8, signed width of each real/imag component.
REQ-002 SHALL have parameter LGSIZE, default 7, log2 of FFT frame length (128 bins).
REQ-003 SHALL have port i_clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_ce  input  1  sample strobe; one FFT bin accepted per cycle with i_ce=1.
REQ-006 SHALL have port i_sync  input  1  qualified by i_ce; marks bin 0 of a frame.
REQ-007 SHALL have port i_result  input  2*IWIDTH  real in [15:8], imag in [7:0], two's complement, natural bin order.
REQ-008 SHALL have port o_valid  output  1  peak report available.
REQ-009 SHALL have port i_ready  input  1  consumer accepts report when o_valid&&i_ready.
REQ-010 SHALL have port o_bin  output  LGSIZE  index of peak bin.
REQ-011 SHALL have port o_mag  output  2*IWIDTH  unsigned re^2+im^2 of peak bin.
REQ-012 SHALL have port o_overrun  output  1  sticky flag: an unconsumed report was overwritten.

Function
REQ-013 SHALL have states IDLE (ignore samples) and ACCUM; IDLE->ACCUM on i_ce&&i_sync; never returns to IDLE except by reset.
REQ-014 SHALL set bin counter to 0 on i_ce&&i_sync, else increment modulo 2^LGSIZE on each i_ce in ACCUM.
REQ-015 SHALL compute magnitude re*re+im*im exactly, unsigned 2*IWIDTH bits (max 32768 for -128,-128, no overflow).
REQ-016 SHALL register magnitude and bin index one cycle after the accepting i_ce cycle (stage 1), independent of later i_ce.
REQ-017 SHALL update running best in stage 2 only when stage-1 magnitude strictly greater than best, or bin is first searched bin; ties keep lowest bin.
REQ-018 SHALL, when stage 2 processes bin 2^LGSIZE-1, load o_bin/o_mag and assert o_valid on the next cycle: o_valid rises 2 clocks after the i_ce cycle carrying bin 127.
REQ-019 SHALL hold o_bin, o_mag, o_valid stable while o_valid&&!i_ready.
REQ-020 SHALL deassert o_valid the cycle after o_valid&&i_ready, unless a new report loads that same cycle, in which case o_valid stays 1 with new data and o_overrun unchanged.
REQ-021 SHALL, if a new report loads while o_valid&&!i_ready, overwrite the report and set o_overrun.
REQ-022 SHALL clear o_overrun on the cycle after a completed transfer.
REQ-023 SHALL, on i_sync arriving mid-frame (counter not at wrap), discard the partial frame without report and restart at bin 0.
REQ-024 SHALL tolerate i_ce gaps of any length; idle cycles neither advance the counter nor alter best.

Reset
REQ-025 SHALL on i_reset: state IDLE, counter 0, best cleared, pipeline valids 0, o_valid 0, o_overrun 0, o_bin 0, o_mag 0.
REQ-026 SHALL let reset take priority over every other event, including a same-cycle report load or transfer.

Configuration
REQ-027 SHALL support macro FFT_PEAK_HALFBAND_EN.
REQ-028 SHALL, with FFT_PEAK_HALFBAND_EN defined, search only bins 1..2^(LGSIZE-1)-1 (1..63); DC and negative bins excluded; result still reported after bin 127.
REQ-029 SHALL, without FFT_PEAK_HALFBAND_EN, search all bins 0..127.

Structure
REQ-030 SHALL place IWIDTH/LGSIZE defaults, magnitude width and state encodings in shared package fft_pkg.
REQ-031 SHALL implement squaring-and-sum stage as sub-module fft_cmag (one-cycle registered latency).

Verification
REQ-032 SHALL cover: reset then one frame, bin 5 = (100,0), others 0 -> o_valid 2 clks after bin 127, o_bin=5, o_mag=10000.
REQ-033 SHALL cover: all bins (-128,-128) -> o_bin=0 (1 with HALFBAND), o_mag=32768.
REQ-034 SHALL cover: bins 10 and 20 both (3,4) -> o_bin=10, o_mag=25 (tie keeps lowest).
REQ-035 SHALL cover: i_ready=0 across two frames, peaks 7 then 9 -> o_bin=9, o_overrun=1; i_ready=1 -> transfer, o_overrun=0 next cycle.
REQ-036 SHALL cover: i_sync at bin 60 with large peak at bin 30 before it -> no report; next full frame reports its own peak only.
REQ-037 SHALL cover: i_ce every 3rd clock, reset asserted at bin 64 -> all outputs 0, no report until next sync-started full frame.
